// File: rtl/parser_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing one parser among several AXI-Stream ingress
// ports; a tag FIFO attributes each parsed metadata pulse back to its ingress port.
module parser_ingress_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned TAG_DEPTH = 4,
  localparam int unsigned PW = $clog2(NUM_PORTS),
  localparam int unsigned CW = $clog2(TAG_DEPTH + 1)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic                          meta_valid_in,
  output logic [PW-1:0]                 meta_port_out,
  output logic                          meta_port_valid,
  output logic [PW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          tag_underflow
);

  localparam int unsigned AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic StIdle   = 1'b0;
  localparam logic StLocked = 1'b1;

  logic          state_q, state_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] rr_pick;
  logic          rr_found;

  logic [PW-1:0] tag_mem_q [TAG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, push, pop, accept_last;

  logic [PW-1:0] meta_port_q;
  logic          meta_valid_q;
  logic          underflow_q;

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      logic [PW-1:0] cand;
      cand = PW'((32'(last_q) + i) % NUM_PORTS);
      if (!rr_found && s_axis_tvalid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign fifo_full   = (count_q == CW'(TAG_DEPTH));
  assign push        = (state_q == StIdle) && rr_found && !fifo_full;
  assign pop         = meta_valid_in && (count_q != '0);
  assign accept_last = (state_q == StLocked) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (push) begin
          grant_d = rr_pick;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (accept_last) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Data path is a pure mux so the parser sees the granted port with no added latency.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == StLocked) begin
      m_axis_tdata           = s_axis_tdata[32'(grant_q)*DATA_W +: DATA_W];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= PW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= rr_pick;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      meta_port_q  <= '0;
      meta_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        meta_port_q <= tag_mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      meta_valid_q <= pop;
      if (meta_valid_in && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign grant_id        = grant_q;
  assign busy            = (state_q == StLocked);
  assign meta_port_out   = meta_port_q;
  assign meta_port_valid = meta_valid_q;
  assign tag_underflow   = underflow_q;

endmodule
